// File: rtl/sme_preamble_stitcher.sv
`default_nettype none
// ============================================================================
// Module  : sme_preamble_stitcher
// Brief   : String-matcher front end. Byte-reverses each AXI-Stream beat so
//           the first byte lands at the MSB, prepends the per-flow carry-over
//           tail, adds an overflow beat when needed and returns the new tail.
// Options : PSTITCH_PKT_LEN_EN adds state_out_len, a saturating byte count.
// Revision: 1.0 - initial release
// ============================================================================
module sme_preamble_stitcher #(
  parameter int BYTE_COUNT = 16,
  parameter int PRE_BYTES  = 7,
  parameter int EMPTY_W    = $clog2(BYTE_COUNT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BYTE_COUNT*8-1:0] s_axis_tdata,
  input  logic [EMPTY_W-1:0]      s_axis_tempty,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  input  logic [PRE_BYTES*8-1:0]  ctx_preamble,
  input  logic                    ctx_has_pre,
  input  logic                    ctx_is_tcp,
  input  logic                    ctx_valid,
  output logic                    ctx_ready,
  output logic [BYTE_COUNT*8-1:0] m_axis_tdata,
  output logic [EMPTY_W-1:0]      m_axis_tempty,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tsop,
  output logic                    m_axis_teop,
  input  logic                    m_axis_tready,
  output logic [PRE_BYTES*8-1:0]  state_out_tail,
  output logic                    state_out_has_pre,
  output logic                    state_out_is_tcp,
`ifdef PSTITCH_PKT_LEN_EN
  output logic [15:0]             state_out_len,
`endif
  output logic                    state_out_valid
);

  localparam int DATA_W     = BYTE_COUNT * 8;
  localparam int PRE_W      = PRE_BYTES * 8;
  localparam int HEAD_BYTES = BYTE_COUNT - PRE_BYTES;
  localparam int HEAD_W     = HEAD_BYTES * 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BODY  = 2'd1,
    ST_EXTRA = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic               has_pre_q, has_pre_d;
  logic               is_tcp_q, is_tcp_d;
  logic               first_q, first_d;
  logic [PRE_W-1:0]   carry_q, carry_d;
  logic [EMPTY_W-1:0] esave_q, esave_d;
  logic [DATA_W-1:0]  m_data_q, m_data_d;
  logic [EMPTY_W-1:0] m_empty_q, m_empty_d;
  logic               m_valid_q, m_valid_d;
  logic               m_sop_q, m_sop_d;
  logic               m_eop_q, m_eop_d;
  logic [PRE_W-1:0]   tail_q, tail_d;
  logic               so_has_pre_q, so_has_pre_d;
  logic               so_is_tcp_q, so_is_tcp_d;
  logic               so_valid_q, so_valid_d;
`ifdef PSTITCH_PKT_LEN_EN
  logic [15:0]        len_q, len_d;
  logic [15:0]        so_len_q, so_len_d;
  logic [16:0]        len_sum;
`endif

  logic [DATA_W-1:0]       rev;
  logic                    out_free;
  logic                    in_accept;
  logic [PRE_W-1:0]        cur_carry;
  logic [PRE_W-1:0]        prior;
  logic [PRE_W+DATA_W-1:0] stream_cat;
  logic [PRE_W-1:0]        new_tail;

  // Byte 0 of the input beat moves to the MSB byte lane
  generate
    for (genvar gi = 0; gi < BYTE_COUNT; gi++) begin : g_rev
      assign rev[(BYTE_COUNT-1-gi)*8 +: 8] = s_axis_tdata[gi*8 +: 8];
    end
  endgenerate

  assign out_free      = !m_valid_q || m_axis_tready;
  assign s_axis_tready = (state_q == ST_BODY) && out_free;
  assign in_accept     = s_axis_tready && s_axis_tvalid;
  assign ctx_ready     = (state_q == ST_IDLE);

  // Bytes that precede this beat in the flow; all-ones when no history exists
  assign cur_carry  = first_q ? pre_q : carry_q;
  assign prior      = first_q ? (has_pre_q ? pre_q : {PRE_W{1'b1}}) : carry_q;
  assign stream_cat = {prior, rev};
  assign new_tail   = PRE_W'(stream_cat >> {s_axis_tempty, 3'b000});

`ifdef PSTITCH_PKT_LEN_EN
  assign len_sum = {1'b0, len_q} + (s_axis_tlast ? (17'(BYTE_COUNT) - 17'(s_axis_tempty))
                                                 : 17'(BYTE_COUNT));
`endif

  // Context FSM, stitching datapath and output register load decisions
  always_comb begin
    state_d      = state_q;
    pre_d        = pre_q;
    has_pre_d    = has_pre_q;
    is_tcp_d     = is_tcp_q;
    first_d      = first_q;
    carry_d      = carry_q;
    esave_d      = esave_q;
    m_data_d     = m_data_q;
    m_empty_d    = m_empty_q;
    m_sop_d      = m_sop_q;
    m_eop_d      = m_eop_q;
    m_valid_d    = m_valid_q && !m_axis_tready;
    tail_d       = tail_q;
    so_has_pre_d = so_has_pre_q;
    so_is_tcp_d  = so_is_tcp_q;
    so_valid_d   = 1'b0;
`ifdef PSTITCH_PKT_LEN_EN
    len_d        = len_q;
    so_len_d     = so_len_q;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef PSTITCH_PKT_LEN_EN
        len_d = 16'd0;
`endif
        if (ctx_valid) begin
          pre_d     = ctx_preamble;
          has_pre_d = ctx_has_pre;
          is_tcp_d  = ctx_is_tcp;
          first_d   = 1'b1;
          state_d   = ST_BODY;
        end
      end
      ST_BODY: begin
        if (in_accept) begin
          first_d   = 1'b0;
          carry_d   = rev[PRE_W-1:0];
          m_valid_d = 1'b1;
          m_sop_d   = first_q;
          m_eop_d   = 1'b0;
          m_empty_d = '0;
          m_data_d  = has_pre_q ? {cur_carry, rev[DATA_W-1:PRE_W]} : rev;
`ifdef PSTITCH_PKT_LEN_EN
          len_d = len_sum[16] ? 16'hFFFF : len_sum[15:0];
`endif
          if (s_axis_tlast) begin
            tail_d       = new_tail;
            so_valid_d   = 1'b1;
            so_has_pre_d = is_tcp_q;
            so_is_tcp_d  = is_tcp_q;
`ifdef PSTITCH_PKT_LEN_EN
            so_len_d = len_sum[16] ? 16'hFFFF : len_sum[15:0];
`endif
            if (!has_pre_q) begin
              m_eop_d   = 1'b1;
              m_empty_d = s_axis_tempty;
              state_d   = ST_IDLE;
            end else if (s_axis_tempty >= EMPTY_W'(PRE_BYTES)) begin
              m_eop_d   = 1'b1;
              m_empty_d = s_axis_tempty - EMPTY_W'(PRE_BYTES);
              state_d   = ST_IDLE;
            end else begin
              // Shifted tail spills past this beat; flush it as its own beat
              esave_d = s_axis_tempty;
              state_d = ST_EXTRA;
            end
          end
        end
      end
      ST_EXTRA: begin
        if (out_free) begin
          m_valid_d = 1'b1;
          m_data_d  = {carry_q, {HEAD_W{1'b1}}};
          m_empty_d = EMPTY_W'(HEAD_BYTES) + esave_q;
          m_sop_d   = 1'b0;
          m_eop_d   = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All state registers; reset drops any pending beat and the carried bytes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pre_q        <= '0;
      has_pre_q    <= 1'b0;
      is_tcp_q     <= 1'b0;
      first_q      <= 1'b0;
      carry_q      <= '0;
      esave_q      <= '0;
      m_data_q     <= '0;
      m_empty_q    <= '0;
      m_valid_q    <= 1'b0;
      m_sop_q      <= 1'b0;
      m_eop_q      <= 1'b0;
      tail_q       <= {PRE_W{1'b1}};
      so_has_pre_q <= 1'b0;
      so_is_tcp_q  <= 1'b0;
      so_valid_q   <= 1'b0;
`ifdef PSTITCH_PKT_LEN_EN
      len_q        <= 16'd0;
      so_len_q     <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      has_pre_q    <= has_pre_d;
      is_tcp_q     <= is_tcp_d;
      first_q      <= first_d;
      carry_q      <= carry_d;
      esave_q      <= esave_d;
      m_data_q     <= m_data_d;
      m_empty_q    <= m_empty_d;
      m_valid_q    <= m_valid_d;
      m_sop_q      <= m_sop_d;
      m_eop_q      <= m_eop_d;
      tail_q       <= tail_d;
      so_has_pre_q <= so_has_pre_d;
      so_is_tcp_q  <= so_is_tcp_d;
      so_valid_q   <= so_valid_d;
`ifdef PSTITCH_PKT_LEN_EN
      len_q        <= len_d;
      so_len_q     <= so_len_d;
`endif
    end
  end

  assign m_axis_tdata      = m_data_q;
  assign m_axis_tempty     = m_empty_q;
  assign m_axis_tvalid     = m_valid_q;
  assign m_axis_tsop       = m_sop_q;
  assign m_axis_teop       = m_eop_q;
  assign state_out_tail    = tail_q;
  assign state_out_has_pre = so_has_pre_q;
  assign state_out_is_tcp  = so_is_tcp_q;
  assign state_out_valid   = so_valid_q;
`ifdef PSTITCH_PKT_LEN_EN
  assign state_out_len     = so_len_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sme_preamble_stitcher.sv
`default_nettype none
// ============================================================================
// Module  : tb_sme_preamble_stitcher
// Brief   : Directed self-checking bench for sme_preamble_stitcher
//           (BYTE_COUNT=16, PRE_BYTES=7).
// Revision: 1.0 - initial release
// ============================================================================
module tb_sme_preamble_stitcher;

  localparam int BC = 16;
  localparam int PB = 7;
  localparam int EW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [BC*8-1:0] s_axis_tdata;
  logic [EW-1:0]   s_axis_tempty;
  logic            s_axis_tvalid;
  logic            s_axis_tlast;
  logic            s_axis_tready;
  logic [PB*8-1:0] ctx_preamble;
  logic            ctx_has_pre;
  logic            ctx_is_tcp;
  logic            ctx_valid;
  logic            ctx_ready;
  logic [BC*8-1:0] m_axis_tdata;
  logic [EW-1:0]   m_axis_tempty;
  logic            m_axis_tvalid;
  logic            m_axis_tsop;
  logic            m_axis_teop;
  logic            m_axis_tready;
  logic [PB*8-1:0] state_out_tail;
  logic            state_out_has_pre;
  logic            state_out_is_tcp;
  logic            state_out_valid;
`ifdef PSTITCH_PKT_LEN_EN
  logic [15:0]     state_out_len;
`endif

  int vectors    = 0;
  int miscompares = 0;

  sme_preamble_stitcher #(.BYTE_COUNT(BC), .PRE_BYTES(PB)) dut (
    .clk               (clk),
    .rst               (rst),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tempty     (s_axis_tempty),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tready     (s_axis_tready),
    .ctx_preamble      (ctx_preamble),
    .ctx_has_pre       (ctx_has_pre),
    .ctx_is_tcp        (ctx_is_tcp),
    .ctx_valid         (ctx_valid),
    .ctx_ready         (ctx_ready),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tempty     (m_axis_tempty),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tsop       (m_axis_tsop),
    .m_axis_teop       (m_axis_teop),
    .m_axis_tready     (m_axis_tready),
    .state_out_tail    (state_out_tail),
    .state_out_has_pre (state_out_has_pre),
    .state_out_is_tcp  (state_out_is_tcp),
`ifdef PSTITCH_PKT_LEN_EN
    .state_out_len     (state_out_len),
`endif
    .state_out_valid   (state_out_valid)
  );

  always #5 clk = ~clk;

  // Input beat whose byte i (bits [8i+7:8i]) holds base+i
  function automatic logic [BC*8-1:0] beat(input logic [7:0] base);
    logic [BC*8-1:0] d;
    for (int i = 0; i < BC; i++) d[i*8 +: 8] = base + 8'(i);
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ctx(input logic [PB*8-1:0] pre, input logic hp, input logic tcp);
    ctx_preamble = pre; ctx_has_pre = hp; ctx_is_tcp = tcp; ctx_valid = 1'b1;
    tick();
    ctx_valid = 1'b0;
  endtask

  task automatic drive_beat(input logic [7:0] base, input logic last, input logic [EW-1:0] emp);
    s_axis_tdata = beat(base); s_axis_tlast = last; s_axis_tempty = emp; s_axis_tvalid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    vectors++;
    if ({m_axis_tvalid, m_axis_tsop, m_axis_teop, state_out_valid} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 0000",
               {m_axis_tvalid, m_axis_tsop, m_axis_teop, state_out_valid});
    end
    vectors++;
    if (m_axis_tdata !== '0 || m_axis_tempty !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got %h/%h expected 0/0", m_axis_tdata, m_axis_tempty);
    end
    vectors++;
    if (state_out_tail !== 56'hFFFFFFFFFFFFFF) begin
      miscompares++;
      $display("FAIL reset_tail: got %h expected ffffffffffffff", state_out_tail);
    end
    vectors++;
    if (ctx_ready !== 1'b1 || s_axis_tready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: got ctx=%b s=%b expected ctx=1 s=0", ctx_ready, s_axis_tready);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_passthrough();
    send_ctx(56'h0, 1'b0, 1'b1);
    drive_beat(8'h00, 1'b1, 4'd0);
    tick();
    s_axis_tvalid = 1'b0;
    vectors++;
    if (m_axis_tdata !== 128'h000102030405060708090A0B0C0D0E0F) begin
      miscompares++;
      $display("FAIL pass_data: got %h expected 000102030405060708090a0b0c0d0e0f", m_axis_tdata);
    end
    vectors++;
    if ({m_axis_tvalid, m_axis_tsop, m_axis_teop} !== 3'b111 || m_axis_tempty !== 4'd0) begin
      miscompares++;
      $display("FAIL pass_ctl: got v/sop/eop=%b empty=%0d expected 111 empty=0",
               {m_axis_tvalid, m_axis_tsop, m_axis_teop}, m_axis_tempty);
    end
    vectors++;
    if (state_out_valid !== 1'b1 || state_out_tail !== 56'h090A0B0C0D0E0F ||
        state_out_has_pre !== 1'b1 || state_out_is_tcp !== 1'b1) begin
      miscompares++;
      $display("FAIL pass_state: got v=%b tail=%h hp=%b tcp=%b expected v=1 tail=090a0b0c0d0e0f hp=1 tcp=1",
               state_out_valid, state_out_tail, state_out_has_pre, state_out_is_tcp);
    end
`ifdef PSTITCH_PKT_LEN_EN
    vectors++;
    if (state_out_len !== 16'd16) begin
      miscompares++;
      $display("FAIL pass_len: got %0d expected 16", state_out_len);
    end
`endif
    tick();
    vectors++;
    if (m_axis_tvalid !== 1'b0 || state_out_valid !== 1'b0 || ctx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL pass_after: got mv=%b sv=%b cr=%b expected 0 0 1",
               m_axis_tvalid, state_out_valid, ctx_ready);
    end
  endtask

  task automatic test_preamble();
    send_ctx(56'hA0A1A2A3A4A5A6, 1'b1, 1'b1);
    drive_beat(8'h00, 1'b1, 4'd9);
    tick();
    s_axis_tvalid = 1'b0;
    vectors++;
    if (m_axis_tdata !== 128'hA0A1A2A3A4A5A6000102030405060708) begin
      miscompares++;
      $display("FAIL pre_data: got %h expected a0a1a2a3a4a5a6000102030405060708", m_axis_tdata);
    end
    vectors++;
    if ({m_axis_tvalid, m_axis_tsop, m_axis_teop} !== 3'b111 || m_axis_tempty !== 4'd2) begin
      miscompares++;
      $display("FAIL pre_ctl: got v/sop/eop=%b empty=%0d expected 111 empty=2",
               {m_axis_tvalid, m_axis_tsop, m_axis_teop}, m_axis_tempty);
    end
    // Valid stream is A0..A6,00..06; the tail is its last seven bytes
    vectors++;
    if (state_out_valid !== 1'b1 || state_out_tail !== 56'h00010203040506) begin
      miscompares++;
      $display("FAIL pre_tail: got v=%b tail=%h expected v=1 tail=00010203040506",
               state_out_valid, state_out_tail);
    end
`ifdef PSTITCH_PKT_LEN_EN
    vectors++;
    if (state_out_len !== 16'd7) begin
      miscompares++;
      $display("FAIL pre_len: got %0d expected 7", state_out_len);
    end
`endif
    tick();
  endtask

  task automatic test_extra_beat();
    send_ctx(56'hB0B1B2B3B4B5B6, 1'b1, 1'b0);
    drive_beat(8'h10, 1'b0, 4'd0);
    tick();
    vectors++;
    if (m_axis_tdata !== 128'hB0B1B2B3B4B5B6101112131415161718 ||
        {m_axis_tvalid, m_axis_tsop, m_axis_teop} !== 3'b110) begin
      miscompares++;
      $display("FAIL extra_b1: got %h v/sop/eop=%b expected b0b1b2b3b4b5b6101112131415161718 110",
               m_axis_tdata, {m_axis_tvalid, m_axis_tsop, m_axis_teop});
    end
    drive_beat(8'h20, 1'b1, 4'd3);
    tick();
    vectors++;
    if (m_axis_tdata !== 128'h191A1B1C1D1E1F202122232425262728 ||
        {m_axis_tvalid, m_axis_tsop, m_axis_teop} !== 3'b100 || m_axis_tempty !== 4'd0) begin
      miscompares++;
      $display("FAIL extra_b2: got %h v/sop/eop=%b e=%0d expected 191a1b1c1d1e1f202122232425262728 100 e=0",
               m_axis_tdata, {m_axis_tvalid, m_axis_tsop, m_axis_teop}, m_axis_tempty);
    end
    vectors++;
    if (state_out_valid !== 1'b1 || state_out_tail !== 56'h262728292A2B2C ||
        state_out_has_pre !== 1'b0 || state_out_is_tcp !== 1'b0) begin
      miscompares++;
      $display("FAIL extra_tail: got v=%b tail=%h hp=%b tcp=%b expected 1 262728292a2b2c 0 0",
               state_out_valid, state_out_tail, state_out_has_pre, state_out_is_tcp);
    end
    drive_beat(8'h50, 1'b0, 4'd0);
    #1;
    vectors++;
    if (s_axis_tready !== 1'b0 || ctx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL extra_ready: got s=%b ctx=%b expected 0 0", s_axis_tready, ctx_ready);
    end
    tick();
    s_axis_tvalid = 1'b0;
    vectors++;
    if (m_axis_tdata !== 128'h292A2B2C2D2E2FFFFFFFFFFFFFFFFFFF ||
        {m_axis_tvalid, m_axis_tsop, m_axis_teop} !== 3'b101 || m_axis_tempty !== 4'd12) begin
      miscompares++;
      $display("FAIL extra_b3: got %h v/sop/eop=%b e=%0d expected 292a2b2c2d2e2fffffffffffffffffff 101 e=12",
               m_axis_tdata, {m_axis_tvalid, m_axis_tsop, m_axis_teop}, m_axis_tempty);
    end
    vectors++;
    if (ctx_ready !== 1'b1 || state_out_valid !== 1'b0 || state_out_tail !== 56'h262728292A2B2C) begin
      miscompares++;
      $display("FAIL extra_done: got cr=%b sv=%b tail=%h expected 1 0 262728292a2b2c",
               ctx_ready, state_out_valid, state_out_tail);
    end
    tick();
  endtask

  task automatic test_back_pressure();
    logic [BC*8-1:0] exp_data [4];
    logic [7:0]      bases [4];
    logic [BC*8-1:0] held_data;
    logic            held;
    logic            acc;
    int              sent;
    int              got;
    exp_data[0] = 128'hC0C1C2C3C4C5C6404142434445464748;
    exp_data[1] = 128'h494A4B4C4D4E4F505152535455565758;
    exp_data[2] = 128'h595A5B5C5D5E5F606162636465666768;
    exp_data[3] = 128'h696A6B6C6D6E6F707172737475767778;
    bases[0] = 8'h40; bases[1] = 8'h50; bases[2] = 8'h60; bases[3] = 8'h70;
    sent = 0;
    got  = 0;
    send_ctx(56'hC0C1C2C3C4C5C6, 1'b1, 1'b1);
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      m_axis_tready = (cyc % 2 == 0);
      if (sent < 4) drive_beat(bases[sent], sent == 3, (sent == 3) ? 4'd8 : 4'd0);
      else s_axis_tvalid = 1'b0;
      #1;
      acc = s_axis_tvalid && s_axis_tready;
      if (m_axis_tvalid && m_axis_tready) begin
        vectors++;
        if (m_axis_tdata !== exp_data[got] || m_axis_tsop !== (got == 0) ||
            m_axis_teop !== (got == 3) || m_axis_tempty !== ((got == 3) ? 4'd1 : 4'd0)) begin
          miscompares++;
          $display("FAIL bp_beat%0d: got %h sop=%b eop=%b e=%0d expected %h", got,
                   m_axis_tdata, m_axis_tsop, m_axis_teop, m_axis_tempty, exp_data[got]);
        end
        got++;
      end
      held      = m_axis_tvalid && !m_axis_tready;
      held_data = m_axis_tdata;
      tick();
      if (acc) sent++;
      if (held) begin
        vectors++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held_data) begin
          miscompares++;
          $display("FAIL bp_hold: got v=%b %h expected v=1 %h", m_axis_tvalid, m_axis_tdata, held_data);
        end
      end
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    vectors++;
    if (got != 4 || sent != 4) begin
      miscompares++;
      $display("FAIL bp_count: got out=%0d in=%0d expected 4 4", got, sent);
    end
    vectors++;
    if (state_out_tail !== 56'h71727374757677) begin
      miscompares++;
      $display("FAIL bp_tail: got %h expected 71727374757677", state_out_tail);
    end
    tick();
  endtask

  task automatic test_ctx_gating();
    drive_beat(8'h80, 1'b1, 4'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (s_axis_tready !== 1'b0 || ctx_ready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL gate_cycle%0d: got s=%b ctx=%b mv=%b expected 0 1 0",
                 i, s_axis_tready, ctx_ready, m_axis_tvalid);
      end
    end
    send_ctx(56'h0, 1'b0, 1'b0);
    vectors++;
    if (s_axis_tready !== 1'b1 || ctx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL gate_open: got s=%b ctx=%b expected 1 0", s_axis_tready, ctx_ready);
    end
    tick();
    s_axis_tvalid = 1'b0;
    vectors++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 128'h808182838485868788898A8B8C8D8E8F) begin
      miscompares++;
      $display("FAIL gate_data: got v=%b %h expected 1 808182838485868788898a8b8c8d8e8f",
               m_axis_tvalid, m_axis_tdata);
    end
    tick();
  endtask

  task automatic test_reset_mid_packet();
    send_ctx(56'hD0D1D2D3D4D5D6, 1'b1, 1'b1);
    drive_beat(8'h90, 1'b0, 4'd0);
    tick();
    drive_beat(8'hA0, 1'b0, 4'd0);
    tick();
    s_axis_tvalid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (m_axis_tvalid !== 1'b0 || ctx_ready !== 1'b1 || s_axis_tready !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_state: got mv=%b ctx=%b s=%b expected 0 1 0",
               m_axis_tvalid, ctx_ready, s_axis_tready);
    end
    send_ctx(56'hE0E1E2E3E4E5E6, 1'b1, 1'b1);
    drive_beat(8'h30, 1'b1, 4'd7);
    tick();
    s_axis_tvalid = 1'b0;
    vectors++;
    if (m_axis_tdata !== 128'hE0E1E2E3E4E5E6303132333435363738 ||
        {m_axis_tvalid, m_axis_tsop, m_axis_teop} !== 3'b111 || m_axis_tempty !== 4'd0) begin
      miscompares++;
      $display("FAIL rstmid_data: got %h v/sop/eop=%b e=%0d expected e0e1e2e3e4e5e6303132333435363738 111 e=0",
               m_axis_tdata, {m_axis_tvalid, m_axis_tsop, m_axis_teop}, m_axis_tempty);
    end
    vectors++;
    if (state_out_valid !== 1'b1 || state_out_tail !== 56'h32333435363738) begin
      miscompares++;
      $display("FAIL rstmid_tail: got v=%b %h expected 1 32333435363738", state_out_valid, state_out_tail);
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tempty = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    ctx_preamble  = '0;
    ctx_has_pre   = 1'b0;
    ctx_is_tcp    = 1'b0;
    ctx_valid     = 1'b0;
    m_axis_tready = 1'b1;
    test_reset();
    test_passthrough();
    test_preamble();
    test_extra_beat();
    test_back_pressure();
    test_ctx_gating();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
